// File: rtl/inst_queue.sv
// Instruction prefetch queue between fetch and control.
// A circular buffer of DEPTH entries. Each entry holds an instruction word and its
// fetch address. The oldest entry is presented at the head. A registered count is the
// only thing that tells full apart from empty. Handshake outputs decode that registered
// count only, so no input has a combinational path to any output.
module inst_queue #(
  parameter int INST_WIDTH = 32,
  parameter int AD_LEN     = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         flush_i,
  input  logic [INST_WIDTH-1:0]        inst_i,
  input  logic [AD_LEN-1:0]            pc_i,
  input  logic                         inst_valid_i,
  output logic                         inst_accept_o,
  output logic [INST_WIDTH-1:0]        inst_o,
  output logic [AD_LEN-1:0]            pc_o,
  output logic                         inst_ready_o,
  input  logic                         inst_consume_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [INST_WIDTH-1:0] inst_mem [DEPTH];
  logic [AD_LEN-1:0]     pc_mem   [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  push;
  logic                  pop;

  // Status decodes the registered count only.
  assign inst_accept_o = (count != CW'(DEPTH));
  assign inst_ready_o  = (count != '0);
  assign count_o       = count;

  // A push cannot happen while full, even with a pop in the same cycle.
  // A consume request while empty has no effect.
  assign push = inst_valid_i & inst_accept_o;
  assign pop  = inst_consume_i & inst_ready_o;

  assign inst_o = inst_mem[rd_ptr];
  assign pc_o   = pc_mem[rd_ptr];

  // Pointer and occupancy control: reset and flush restart the ring at index 0.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage: cleared on reset so the head reads zero afterwards, written on an accepted push.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (push && !flush_i) begin
      inst_mem[wr_ptr] <= inst_i;
      pc_mem[wr_ptr]   <= pc_i;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue. The stimulus side pushes expected {inst, pc} pairs.
// A separate monitor pops them and compares each time the head is consumed.
module tb_inst_queue;

  localparam int INST_WIDTH = 32;
  localparam int AD_LEN     = 32;
  localparam int DEPTH      = 4;
  localparam int CW         = $clog2(DEPTH + 1);

  logic                  clk_i = 1'b0;
  logic                  reset_i = 1'b1;
  logic                  flush_i = 1'b0;
  logic [INST_WIDTH-1:0] inst_i = '0;
  logic [AD_LEN-1:0]     pc_i = '0;
  logic                  inst_valid_i = 1'b0;
  logic                  inst_accept_o;
  logic [INST_WIDTH-1:0] inst_o;
  logic [AD_LEN-1:0]     pc_o;
  logic                  inst_ready_o;
  logic                  inst_consume_i = 1'b0;
  logic [CW-1:0]         count_o;

  int errors = 0;
  int checks = 0;
  int mcount = 0;
  logic [63:0] exp_q[$];

  inst_queue #(.INST_WIDTH(INST_WIDTH), .AD_LEN(AD_LEN), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .inst_i(inst_i), .pc_i(pc_i), .inst_valid_i(inst_valid_i),
    .inst_accept_o(inst_accept_o), .inst_o(inst_o), .pc_o(pc_o),
    .inst_ready_o(inst_ready_o), .inst_consume_i(inst_consume_i), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a consume that the DUT accepts must present the oldest expected entry.
  always @(negedge clk_i) begin
    if (!reset_i && !flush_i && inst_ready_o && inst_consume_i) begin
      if (exp_q.size() == 0) begin
        chk("pop_on_empty_model", 64'd1, 64'd0);
      end else begin
        chk("head_inst_pc", {inst_o, pc_o}, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
  end

  // Compares count, ready and accept against the model occupancy.
  task automatic check_status();
    logic [CW-1:0] ec;
    ec = CW'(mcount);
    chk("status_cnt_rdy_acc", {56'd0, count_o, inst_ready_o, inst_accept_o},
        {56'd0, ec, 1'(mcount != 0), 1'(mcount != DEPTH)});
    chk("count_le_depth", 64'(count_o <= CW'(DEPTH)), 64'd1);
  endtask

  // One clock cycle of stimulus with model update.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                      input logic c, input logic f);
    logic push_e, pop_e;
    check_status();
    inst_valid_i   = v;
    inst_i         = ins;
    pc_i           = p;
    inst_consume_i = c;
    flush_i        = f;
    push_e = v && (mcount != DEPTH) && !f;
    pop_e  = c && (mcount != 0) && !f;
    if (push_e) exp_q.push_back({ins, p});
    @(posedge clk_i); #1;
    if (f) begin
      mcount = 0;
      exp_q.delete();
    end else begin
      mcount = mcount + int'(push_e) - int'(pop_e);
    end
    inst_valid_i   = 1'b0;
    inst_consume_i = 1'b0;
    flush_i        = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset held two cycles
    reset_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    chk("reset_accept", 64'(inst_accept_o), 64'd1);
    chk("reset_ready", 64'(inst_ready_o), 64'd0);
    chk("reset_count", 64'(count_o), 64'd0);
    chk("reset_inst", 64'(inst_o), 64'd0);
    chk("reset_pc", 64'(pc_o), 64'd0);

    // 2: fill to full, one extra push dropped, drain in order
    for (int i = 0; i < 4; i++) step(1'b1, 32'hA0 + i, 32'(4 * i), 1'b0, 1'b0);
    chk("full_count", 64'(count_o), 64'd4);
    chk("full_accept", 64'(inst_accept_o), 64'd0);
    step(1'b1, 32'hA4, 32'h10, 1'b0, 1'b0);
    chk("drop_count", 64'(count_o), 64'd4);
    chk("head_after_fill", {inst_o, pc_o}, {32'hA0, 32'h0});
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("drained_ready", 64'(inst_ready_o), 64'd0);

    // 3: two entries, then push and pop together across pointer wrap
    step(1'b1, 32'hC0, 32'h100, 1'b0, 1'b0);
    step(1'b1, 32'hC1, 32'h104, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 32'hC2 + i, 32'h108 + 32'(4 * i), 1'b1, 1'b0);
    chk("simul_count", 64'(count_o), 64'd2);

    // 4: full with push and pop requested -> pop only
    step(1'b1, 32'hD0, 32'h200, 1'b0, 1'b0);
    step(1'b1, 32'hD1, 32'h204, 1'b0, 1'b0);
    chk("full2_count", 64'(count_o), 64'd4);
    step(1'b1, 32'hDE, 32'h2FC, 1'b1, 1'b0);
    chk("full_pushpop_count", 64'(count_o), 64'd3);

    // 5: flush at count 3 with push and pop asserted
    step(1'b1, 32'hEE, 32'h300, 1'b1, 1'b1);
    chk("flush_count", 64'(count_o), 64'd0);
    chk("flush_ready", 64'(inst_ready_o), 64'd0);
    step(1'b1, 32'hB0, 32'h400, 1'b0, 1'b0);
    chk("post_flush_head", {inst_o, pc_o}, {32'hB0, 32'h400});
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // 6: consume while empty, then random traffic against the model
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("empty_pop_count", 64'(count_o), 64'd0);
    chk("empty_pop_accept", 64'(inst_accept_o), 64'd1);
    for (int i = 0; i < 1000; i++)
      step(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    while (mcount != 0) step(1'b0, '0, '0, 1'b1, 1'b0);
    check_status();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
